// File: rtl/disp_pkg_amisha.sv
// Shared types and constants for the display scheduler.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package disp_pkg_amisha;

  localparam int NREQ  = 4;
  localparam int DIG_W = 16;
  localparam int DP_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Convert a one-hot requester vector into its index (0 when empty).
  function automatic logic [1:0] onehot2idx(input logic [NREQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arb_amisha.sv
// Round-robin picker: first requester strictly after last_gnt_i, wrapping 3->0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is taken.
module rr_arb_amisha
  import disp_pkg_amisha::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic [1:0]      last_gnt_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            vld_o
);

  logic [1:0] idx;
  logic       found;

  // Scan from the requester after the last owner so the previous owner comes last.
  always_comb begin
    gnt_o = '0;
    idx   = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = 2'(last_gnt_i + 2'(k));
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    vld_o = found;
  end

endmodule

// File: rtl/disp_sched_amisha.sv
// Shares the 4-digit display among 4 requesters: round-robin ownership, dwell, blank gaps.
// Latency: request/data to gnt/display one cycle; done pulses with the edge that clears gnt.
// Backpressure: owners release early by dropping req; DISP_SCHED_PRIO_EN makes requester 0 preempt.
module disp_sched_amisha
  import disp_pkg_amisha::*;
#(
  parameter int DWELL = 200,
  parameter int GAP   = 2
) (
  input  logic                    clk_amisha,
  input  logic                    reset_amisha,
  input  logic [NREQ-1:0]         req_amisha,
  input  logic [NREQ*DIG_W-1:0]   data_amisha,
  input  logic [NREQ*DP_W-1:0]    dp_amisha,
  output logic [NREQ-1:0]         gnt_amisha,
  output logic [DIG_W-1:0]        disp_val_amisha,
  output logic [DP_W-1:0]         dp_in_amisha,
  output logic                    blank_amisha,
  output logic [NREQ-1:0]         done_amisha
);

  localparam logic [15:0] DWELL_INIT = 16'(DWELL - 1);
  localparam logic [7:0]  GAP_INIT   = 8'(GAP - 1);

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [DIG_W-1:0]  disp_q, disp_d;
  logic [DP_W-1:0]   dp_q, dp_d;
  logic              blank_q, blank_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [1:0]        last_q, last_d;
  logic [15:0]       dwell_q, dwell_d;
  logic [7:0]        gap_q, gap_d;

  logic [NREQ-1:0]   arb_gnt, pick_gnt;
  logic              arb_vld, pick_vld, preempt, arb_en;
  logic [1:0]        pick_idx;
  logic [DIG_W-1:0]  own_dat, new_dat;
  logic [DP_W-1:0]   own_dp, new_dp;

  rr_arb_amisha u_arb (
    .req_i      (req_amisha),
    .last_gnt_i (last_q),
    .gnt_o      (arb_gnt),
    .vld_o      (arb_vld)
  );

`ifdef DISP_SCHED_PRIO_EN
  // Requester 0 is urgent: it wins every arbitration and cuts any other owner short.
  assign pick_gnt = req_amisha[0] ? 4'b0001 : arb_gnt;
  assign preempt  = req_amisha[0] && (last_q != 2'd0);
`else
  assign pick_gnt = arb_gnt;
  assign preempt  = 1'b0;
`endif
  assign pick_vld = arb_vld;
  assign pick_idx = onehot2idx(pick_gnt);

  // While showing, last_q is the current owner.
  assign own_dat = data_amisha[{last_q, 4'b0000} +: DIG_W];
  assign own_dp  = dp_amisha[{last_q, 2'b00} +: DP_W];
  assign new_dat = data_amisha[{pick_idx, 4'b0000} +: DIG_W];
  assign new_dp  = dp_amisha[{pick_idx, 2'b00} +: DP_W];

  // Next-state logic: slot timing, gap insertion and arbitration on IDLE / end of GAP.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    disp_d  = disp_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    done_d  = '0;
    last_d  = last_q;
    dwell_d = dwell_q;
    gap_d   = gap_q;
    arb_en  = 1'b0;
    case (state_q)
      ST_IDLE: arb_en = 1'b1;
      ST_SHOW: begin
        // Dwell expiry, release and preemption all collapse into one exit, so one done pulse.
        if (dwell_q == 16'd0 || !req_amisha[last_q] || preempt) begin
          done_d  = gnt_q;
          gnt_d   = '0;
          disp_d  = '0;
          dp_d    = '0;
          blank_d = 1'b1;
          gap_d   = GAP_INIT;
          state_d = ST_GAP;
        end else begin
          dwell_d = dwell_q - 16'd1;
          disp_d  = own_dat;
          dp_d    = own_dp;
        end
      end
      ST_GAP: begin
        if (gap_q == 8'd0) arb_en = 1'b1;
        else               gap_d  = gap_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (arb_en) begin
      if (pick_vld) begin
        gnt_d   = pick_gnt;
        last_d  = pick_idx;
        dwell_d = DWELL_INIT;
        disp_d  = new_dat;
        dp_d    = new_dp;
        blank_d = 1'b0;
        state_d = ST_SHOW;
      end else begin
        gnt_d   = '0;
        disp_d  = '0;
        dp_d    = '0;
        blank_d = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

  // State registers; last_q resets to 3 so requester 0 is first in line.
  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      disp_q  <= '0;
      dp_q    <= '0;
      blank_q <= 1'b1;
      done_q  <= '0;
      last_q  <= 2'd3;
      dwell_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      disp_q  <= disp_d;
      dp_q    <= dp_d;
      blank_q <= blank_d;
      done_q  <= done_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      gap_q   <= gap_d;
    end
  end

  assign gnt_amisha      = gnt_q;
  assign disp_val_amisha = disp_q;
  assign dp_in_amisha    = dp_q;
  assign blank_amisha    = blank_q;
  assign done_amisha     = done_q;

endmodule

// File: tb/tb_disp_sched_amisha.sv
// Bench for disp_sched_amisha with DWELL=4, GAP=2 against a slot-level reference model.
// Latency: model predicts outputs visible one cycle after each sampled input.
// Backpressure: exercised through early release and, with DISP_SCHED_PRIO_EN, preemption.
module tb_disp_sched_amisha;

  localparam int DW = 4;
  localparam int GP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] data;
  logic [15:0] dp;
  logic [3:0]  gnt;
  logic [15:0] disp;
  logic [3:0]  dpo;
  logic        blank;
  logic [3:0]  done;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the display, how long it has been shown, gap left, RR pointer.
  int          m_owner;
  int          m_shown;
  int          m_gap_left;
  int          m_ptr;
  logic [3:0]  m_gnt;
  logic [15:0] m_disp;
  logic [3:0]  m_dp;
  logic        m_blank;
  logic [3:0]  m_done;

  always #5 clk = ~clk;

  disp_sched_amisha #(.DWELL(DW), .GAP(GP)) dut (
    .clk_amisha      (clk),
    .reset_amisha    (rst),
    .req_amisha      (req),
    .data_amisha     (data),
    .dp_amisha       (dp),
    .gnt_amisha      (gnt),
    .disp_val_amisha (disp),
    .dp_in_amisha    (dpo),
    .blank_amisha    (blank),
    .done_amisha     (done)
  );

  task automatic model_grant();
    int pick;
    pick = -1;
`ifdef DISP_SCHED_PRIO_EN
    if (req[0]) pick = 0;
`endif
    for (int k = 1; k <= 4; k++) begin
      if (pick < 0 && req[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
    end
    if (pick >= 0) begin
      m_owner = pick;
      m_ptr   = pick;
      m_shown = 0;
      m_gnt   = 4'(1 << pick);
      m_disp  = data[16*pick +: 16];
      m_dp    = dp[4*pick +: 4];
      m_blank = 1'b0;
    end else begin
      m_gnt   = 4'b0;
      m_disp  = 16'h0;
      m_dp    = 4'h0;
      m_blank = 1'b1;
    end
  endtask

  task automatic model_edge();
    bit ended;
    m_done = 4'b0;
    if (rst) begin
      m_owner = -1; m_gap_left = 0; m_ptr = 3; m_shown = 0;
      m_gnt = 4'b0; m_disp = 16'h0; m_dp = 4'h0; m_blank = 1'b1;
      return;
    end
    if (m_owner >= 0) begin
      m_shown++;
      ended = (m_shown == DW) || !req[m_owner];
`ifdef DISP_SCHED_PRIO_EN
      if (req[0] && m_owner != 0) ended = 1'b1;
`endif
      if (ended) begin
        m_done[m_owner] = 1'b1;
        m_owner = -1; m_gap_left = GP;
        m_gnt = 4'b0; m_disp = 16'h0; m_dp = 4'h0; m_blank = 1'b1;
      end else begin
        m_disp = data[16*m_owner +: 16];
        m_dp   = dp[4*m_owner +: 4];
      end
    end else if (m_gap_left > 1) begin
      m_gap_left--;
    end else begin
      m_gap_left = 0;
      model_grant();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b0; data = 64'h0; dp = 16'h0;
    tick(); tick();
    checks++;
    if ({gnt, disp, dpo, blank, done} !== {4'b0, 16'h0, 4'h0, 1'b1, 4'b0}) begin
      failures++;
      $display("FAIL reset_values got=%h exp=%h", {gnt, disp, dpo, blank, done}, {4'b0, 16'h0, 4'h0, 1'b1, 4'b0});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (blank !== 1'b1 || gnt !== 4'b0) begin
      failures++;
      $display("FAIL idle_blank got gnt=%b blank=%b exp gnt=0000 blank=1", gnt, blank);
    end
  endtask

  task automatic test_single();
    logic [3:0] eg, ed;
    do_reset();
    data = 64'h0; data[31:16] = 16'h1A2B; req = 4'b0010;
    for (int t = 0; t <= 6; t++) begin
      tick();
      eg = (t < 4 || t == 6) ? 4'b0010 : 4'b0000;
      ed = (t == 4) ? 4'b0010 : 4'b0000;
      checks++;
      if (gnt !== eg || done !== ed || blank !== (t == 4 || t == 5) ||
          disp !== ((t == 4 || t == 5) ? 16'h0 : 16'h1A2B)) begin
        failures++;
        $display("FAIL single t=%0d got gnt=%b done=%b blank=%b disp=%h exp gnt=%b done=%b", t, gnt, done, blank, disp, eg, ed);
      end
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int at[$];
    logic [3:0] prev;
    do_reset();
    req = 4'b1111; data = {$urandom, $urandom}; dp = 16'($urandom);
    prev = 4'b0;
    for (int t = 0; t < 40 && order.size() < 5; t++) begin
      tick();
      checks++;
      if ({gnt, disp, dpo, blank, done} !== {m_gnt, m_disp, m_dp, m_blank, m_done}) begin
        failures++;
        $display("FAIL rr_model t=%0d got=%h exp=%h", t, {gnt, disp, dpo, blank, done}, {m_gnt, m_disp, m_dp, m_blank, m_done});
      end
      if (prev == 4'b0 && gnt != 4'b0) begin
        for (int i = 0; i < 4; i++) if (gnt[i]) order.push_back(i);
        at.push_back(t);
      end
      prev = gnt;
    end
    checks++;
    if (order.size() != 5) begin
      failures++;
      $display("FAIL rr_count got=%0d exp=5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
`ifdef DISP_SCHED_PRIO_EN
        if (order[i] != 0 || at[i] != i * (DW + GP)) begin
          failures++;
          $display("FAIL rr_order i=%0d got=%0d@%0d exp=0@%0d", i, order[i], at[i], i * (DW + GP));
        end
`else
        if (order[i] != i % 4 || at[i] != i * (DW + GP)) begin
          failures++;
          $display("FAIL rr_order i=%0d got=%0d@%0d exp=%0d@%0d", i, order[i], at[i], i % 4, i * (DW + GP));
        end
`endif
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    req = 4'b0100;
    tick();
    tick();
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0 || done !== 4'b0100 || blank !== 1'b1) begin
      failures++;
      $display("FAIL early_release got gnt=%b done=%b blank=%b exp gnt=0000 done=0100 blank=1", gnt, done, blank);
    end
    for (int t = 0; t < 3; t++) begin
      tick();
      checks++;
      if (blank !== 1'b1 || done !== 4'b0 || gnt !== 4'b0) begin
        failures++;
        $display("FAIL early_gap t=%0d got gnt=%b done=%b blank=%b exp gnt=0000 done=0000 blank=1", t, gnt, done, blank);
      end
    end
  endtask

  task automatic test_live_data();
    do_reset();
    data = 64'h0; dp = 16'h0; dp[15:12] = 4'b0101; req = 4'b1000;
    tick();
    checks++;
    if (gnt !== 4'b1000 || disp !== 16'h0000 || dpo !== 4'b0101 || blank !== 1'b0) begin
      failures++;
      $display("FAIL live_first got gnt=%b disp=%h dp=%b exp gnt=1000 disp=0000 dp=0101", gnt, disp, dpo);
    end
    data[63:48] = 16'hFFFF;
    tick();
    checks++;
    if (disp !== 16'hFFFF || dpo !== 4'b0101) begin
      failures++;
      $display("FAIL live_follow got disp=%h dp=%b exp disp=ffff dp=0101", disp, dpo);
    end
  endtask

  task automatic test_reset_mid_show();
    do_reset();
    req = 4'b0010;
    tick(); tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({gnt, disp, dpo, blank, done} !== {4'b0, 16'h0, 4'h0, 1'b1, 4'b0}) begin
      failures++;
      $display("FAIL reset_mid_show got=%h exp=%h", {gnt, disp, dpo, blank, done}, {4'b0, 16'h0, 4'h0, 1'b1, 4'b0});
    end
    rst = 1'b0; req = 4'b0011;
    tick();
    checks++;
    if (gnt !== 4'b0001 || done !== 4'b0) begin
      failures++;
      $display("FAIL reset_rearb got gnt=%b done=%b exp gnt=0001 done=0000", gnt, done);
    end
  endtask

  task automatic test_preempt();
    int done_t, g0_t;
    do_reset();
    req = 4'b0100; done_t = -1; g0_t = -1;
    for (int t = 0; t < 8; t++) begin
      if (t == 2) req = 4'b0101;
      tick();
      if (done == 4'b0100 && done_t < 0) done_t = t;
      if (gnt == 4'b0001 && g0_t < 0) g0_t = t;
    end
    checks++;
`ifdef DISP_SCHED_PRIO_EN
    if (done_t != 2 || g0_t != 4) begin
      failures++;
      $display("FAIL preempt got done@%0d gnt0@%0d exp done@2 gnt0@4", done_t, g0_t);
    end
`else
    if (done_t != 4 || g0_t != 6) begin
      failures++;
      $display("FAIL no_preempt got done@%0d gnt0@%0d exp done@4 gnt0@6", done_t, g0_t);
    end
`endif
  endtask

  task automatic test_random();
    do_reset();
    req = 4'($urandom);
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 5) == 0) req = 4'($urandom);
      rst  = ($urandom_range(0, 63) == 0);
      data = {$urandom, $urandom};
      dp   = 16'($urandom);
      tick();
      checks++;
      if ({gnt, disp, dpo, blank, done} !== {m_gnt, m_disp, m_dp, m_blank, m_done}) begin
        failures++;
        $display("FAIL random t=%0d req=%b got=%h exp=%h", t, req, {gnt, disp, dpo, blank, done}, {m_gnt, m_disp, m_dp, m_blank, m_done});
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 4'b0; data = 64'h0; dp = 16'h0;
    m_owner = -1; m_shown = 0; m_gap_left = 0; m_ptr = 3;
    m_gnt = 4'b0; m_disp = 16'h0; m_dp = 4'h0; m_blank = 1'b1; m_done = 4'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_live_data();
    test_reset_mid_show();
    test_preempt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
